sparse_idx_encoder_4x5: RTL and testbench

SPARSE_IDX_ENCODER_4X5 -- requirements
Module: sparse_idx_encoder_4x5

---
 rtl/sparse_idx_encoder_4x5_pkg.sv | 17 +
 rtl/sparse_idx_encoder_4x5_pick.sv | 38 +++
 rtl/sparse_idx_encoder_4x5.sv | 115 +++++++++++
 tb/tb_sparse_idx_encoder_4x5.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/sparse_idx_encoder_4x5_pkg.sv
// Shared constants for the 4-of-5 sparse weight encoder and its selector.
// Group geometry, index codes and a magnitude helper.
package sparse_idx_encoder_4x5_pkg;

    localparam int NG_P = 4;
    localparam int GW   = 5;
    localparam int WW   = 4;
    localparam int IW   = 3;

    localparam logic [IW-1:0] POS4_CODE = 3'b100;

    // Unsigned magnitude of a 4-bit two's-complement weight; |-8| = 8.
    function automatic logic [WW-1:0] wmag(input logic [WW-1:0] w);
        return w[WW-1] ? (~w + 4'd1) : w;
    endfunction

endpackage

// File: rtl/sparse_idx_encoder_4x5_pick.sv
// One-group picker: largest-magnitude weight of five, lowest position wins.
// Purely combinational; also flags all-zero and multi-nonzero groups.
module group_idx_pick
    import sparse_idx_encoder_4x5_pkg::*;
(
    input  logic [GW*WW-1:0] grp_i,
    output logic [IW-1:0]    idx_o,
    output logic [WW-1:0]    w_o,
    output logic             zero_o,
    output logic             viol_o
);

    logic [2:0]    best_p;
    logic [WW-1:0] best_m;
    logic [2:0]    nz;

    // Scan positions in order; strict compare keeps the lowest on ties.
    always_comb begin
        best_p = '0;
        best_m = '0;
        nz     = '0;
        for (int p = 0; p < GW; p++) begin
            if (wmag(grp_i[WW*p +: WW]) > best_m) begin
                best_m = wmag(grp_i[WW*p +: WW]);
                best_p = 3'(p);
            end
            if (grp_i[WW*p +: WW] != '0) begin
                nz = nz + 3'd1;
            end
        end
    end

    assign idx_o  = (best_p == 3'd4) ? POS4_CODE : {1'b0, best_p[1:0]};
    assign w_o    = grp_i[WW*best_p +: WW];
    assign zero_o = (grp_i == '0);
    assign viol_o = (nz > 3'd1);

endmodule

// File: rtl/sparse_idx_encoder_4x5.sv
// Two-stage sparse weight encoder: S1 holds dense weights, S2 holds picks.
// Counts groups that lose information (more than one nonzero weight).
module sparse_idx_encoder_4x5
    import sparse_idx_encoder_4x5_pkg::*;
#(
    parameter int NG    = NG_P,
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [NG*GW*WW-1:0] in_w,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [NG*WW-1:0]    out_w,
    output logic [NG*IW-1:0]    out_idx,
    output logic [NG-1:0]       out_zero,
    input  logic                clr_cnt,
    output logic [CNT_W-1:0]    viol_cnt
);

    logic                s1_valid_q;
    logic [NG*GW*WW-1:0] s1_w_q;
    logic                s2_valid_q;
    logic [NG*WW-1:0]    s2_w_q;
    logic [NG*IW-1:0]    s2_idx_q;
    logic [NG-1:0]       s2_zero_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_d;

    logic [NG*WW-1:0]    pick_w;
    logic [NG*IW-1:0]    pick_idx;
    logic [NG-1:0]       pick_zero;
    logic [NG-1:0]       pick_viol;

    logic                s2_adv;
    logic                s1_adv;
    logic                move;
    logic [CNT_W-1:0]    inc;
    logic [CNT_W:0]      sum;

    assign s2_adv   = !s2_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = s1_adv;
    assign move     = s1_valid_q && s2_adv;

    for (genvar g = 0; g < NG; g++) begin : g_pick
        group_idx_pick u_pick (
            .grp_i  (s1_w_q[g*GW*WW +: GW*WW]),
            .idx_o  (pick_idx[g*IW +: IW]),
            .w_o    (pick_w[g*WW +: WW]),
            .zero_o (pick_zero[g]),
            .viol_o (pick_viol[g])
        );
    end

    // Sum violating groups of the beat leaving S1, saturating at all-ones.
    always_comb begin
        inc = '0;
        for (int g = 0; g < NG; g++) begin
            inc = inc + CNT_W'(pick_viol[g]);
        end
        sum   = {1'b0, cnt_q} + {1'b0, inc};
        cnt_d = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    end

    // S1: capture dense weights whenever the stage can advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_w_q     <= '0;
        end else if (s1_adv) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_w_q <= in_w;
            end
        end
    end

    // S2: register picks; held steady while downstream stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            s2_w_q     <= '0;
            s2_idx_q   <= '0;
            s2_zero_q  <= '0;
        end else if (s2_adv) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_w_q    <= pick_w;
                s2_idx_q  <= pick_idx;
                s2_zero_q <= pick_zero;
            end
        end
    end

    // Violation counter; clear takes priority over a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr_cnt) begin
            cnt_q <= '0;
        end else if (move) begin
            cnt_q <= cnt_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_w     = s2_w_q;
    assign out_idx   = s2_idx_q;
    assign out_zero  = s2_zero_q;
    assign viol_cnt  = cnt_q;

endmodule

// File: tb/tb_sparse_idx_encoder_4x5.sv
// Scoreboard bench for the sparse index encoder.
// Directed beats with hand-computed picks, stalls, reset and saturation.
module tb_sparse_idx_encoder_4x5;

    typedef struct packed {
        logic [15:0] w;
        logic [11:0] idx;
        logic [3:0]  zero;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [79:0] in_w;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_w;
    logic [11:0] out_idx;
    logic [3:0]  out_zero;
    logic        clr_cnt;
    logic [15:0] viol_cnt;

    exp_t q[$];
    int   total;
    int   bad;
    int   stall_seen;
    logic held;
    exp_t held_v;

    sparse_idx_encoder_4x5 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_w      (in_w),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_w     (out_w),
        .out_idx   (out_idx),
        .out_zero  (out_zero),
        .clr_cnt   (clr_cnt),
        .viol_cnt  (viol_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [19:0] grp(
        input logic [3:0] p0, input logic [3:0] p1, input logic [3:0] p2,
        input logic [3:0] p3, input logic [3:0] p4);
        return {p4, p3, p2, p1, p0};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Monitor: pop on every output handshake, and check stability on stalls.
    always @(negedge clk) begin
        if (!rst_n) begin
            held = 1'b0;
        end else if (out_valid && out_ready) begin
            held = 1'b0;
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_beat: got %h/%h/%h want none",
                         out_w, out_idx, out_zero);
            end else begin
                chk("beat", {out_w, out_idx, out_zero}, q.pop_front());
            end
        end else if (out_valid && !out_ready) begin
            if (held) chk("stall_hold", {out_w, out_idx, out_zero}, held_v);
            held_v = {out_w, out_idx, out_zero};
            held   = 1'b1;
        end else begin
            held = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (in_valid && !in_ready) stall_seen++;
    end

    task automatic send(input logic [79:0] v, input exp_t e);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_w     = v;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got in_ready=0 want 1");
        end else begin
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_w     = '0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("drain_empty", q.size(), 0);
    endtask

    logic [79:0] v1, v2, v3, v4, va, vb, vc;
    exp_t        e1, e2, e3, e4, ea, eb, ec;

    initial begin
        total      = 0;
        bad        = 0;
        stall_seen = 0;
        held       = 1'b0;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_w       = '0;
        out_ready  = 1'b1;
        clr_cnt    = 1'b0;

        v1 = {60'h0, grp(4'h0, 4'h0, 4'h3, 4'h0, 4'h0)};
        e1 = '{16'h0003, 12'b000_000_000_010, 4'b1110};
        v2 = {40'h0, grp(4'h0, 4'h7, 4'h0, 4'h0, 4'h8), 20'h0};
        e2 = '{16'h0080, 12'b000_000_100_000, 4'b1101};
        v3 = {20'h0, grp(4'h5, 4'h0, 4'h0, 4'hB, 4'h0), 40'h0};
        e3 = '{16'h0500, 12'b000_000_000_000, 4'b1011};
        v4 = {grp(4'h0, 4'h0, 4'h0, 4'h6, 4'h6),
              grp(4'h8, 4'h7, 4'h7, 4'h8, 4'h0),
              grp(4'h0, 4'h0, 4'h0, 4'h0, 4'hF),
              grp(4'h1, 4'hE, 4'h0, 4'h0, 4'h0)};
        e4 = '{16'h68FE, 12'b011_000_100_001, 4'b0000};
        va = {4{grp(4'h1, 4'h1, 4'h0, 4'h0, 4'h0)}};
        ea = '{16'h1111, 12'h000, 4'b0000};
        vb = {40'h0, {2{grp(4'h1, 4'h1, 4'h0, 4'h0, 4'h0)}}};
        eb = '{16'h0011, 12'h000, 4'b1100};
        vc = {20'h0, {3{grp(4'h1, 4'h1, 4'h0, 4'h0, 4'h0)}}};
        ec = '{16'h0111, 12'h000, 4'b1000};

        #12;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_outs", {out_w, out_idx, out_zero}, 0);
        chk("rst_viol", viol_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        send(v1, e1);
        send(v2, e2);
        send(v3, e3);
        send(v4, e4);
        drain();
        chk("viol_basic", viol_cnt, 5);

        stall_seen = 0;
        fork
            begin
                send(v1, e1);
                send(v2, e2);
                send(v3, e3);
                send(v4, e4);
                send(v2, e2);
                send(v4, e4);
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (4) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        chk("bp_in_ready_fell", stall_seen != 0, 1);
        chk("viol_bp", viol_cnt, 14);

        out_ready = 1'b0;
        send(v4, e4);
        send(v4, e4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_fly_out_valid", out_valid, 0);
        chk("rst_fly_in_ready", in_ready, 1);
        chk("rst_fly_outs", {out_w, out_idx, out_zero}, 0);
        chk("rst_fly_viol", viol_cnt, 0);
        q.delete();
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("rst_no_stale", out_valid, 0);

        for (int i = 0; i < 16383; i++) send(va, ea);
        send(vb, eb);
        drain();
        chk("viol_preload", viol_cnt, 16'hFFFE);
        send(vc, ec);
        drain();
        chk("viol_sat", viol_cnt, 16'hFFFF);
        send(va, ea);
        drain();
        chk("viol_sat_hold", viol_cnt, 16'hFFFF);
        send(va, ea);
        clr_cnt = 1'b1;
        @(posedge clk);
        #1;
        clr_cnt = 1'b0;
        chk("viol_clr_wins", viol_cnt, 0);
        drain();
        chk("viol_clr_after", viol_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
